spike_rate_decoder: RTL



---
 rtl/spike_rate_decoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// Decodes a 1-bit spike train into a windowed spike count (rate code) and the
// interval between the two most recent spike events (temporal code).
module spike_rate_decoder #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16,
    parameter int ISI_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             spike,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};

    logic [0:0]       state;
    logic             spike_d;
    logic             have_prev;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt;
    logic [ISI_W-1:0] timer;

    logic             spike_evt;
    logic             win_end;
    logic [WIN_W-1:0] win_len_eff;
    logic [CNT_W-1:0] spk_next;
    logic [ISI_W-1:0] timer_next;

    // A held-high spike line is a single event: only the rising edge counts.
    assign spike_evt   = spike & ~spike_d;
    assign win_len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    assign win_end     = (win_cnt == len_q - WIN_W'(1));
    assign spk_next    = (spk_cnt == CNT_MAX) ? CNT_MAX
                                              : spk_cnt + CNT_W'(spike_evt);
    assign timer_next  = (timer == ISI_MAX) ? ISI_MAX : timer + ISI_W'(1);

    // NOTE: every register here is written with <= so all of them sample the
    // pre-edge values; a blocking assignment would let later lines see new state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            spike_d    <= 1'b0;
            have_prev  <= 1'b0;
            len_q      <= '0;
            win_cnt    <= '0;
            spk_cnt    <= '0;
            timer      <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            isi        <= '0;
            isi_valid  <= 1'b0;
        end else begin
            spike_d <= spike;

            if (clear) begin
                // State is kept so a running decoder opens a fresh window next cycle.
                rate       <= '0;
                rate_valid <= 1'b0;
                isi        <= '0;
                isi_valid  <= 1'b0;
                spk_cnt    <= '0;
                win_cnt    <= '0;
                timer      <= '0;
                have_prev  <= 1'b0;
                len_q      <= win_len_eff;
            end else if (!ena) begin
                state      <= IDLE;
                win_cnt    <= '0;
                spk_cnt    <= '0;
                timer      <= '0;
                have_prev  <= 1'b0;
                rate_valid <= 1'b0;
                isi_valid  <= 1'b0;
            end else if (state == IDLE) begin
                state      <= RUN;
                win_cnt    <= '0;
                len_q      <= win_len_eff;
                rate_valid <= 1'b0;
                isi_valid  <= 1'b0;
            end else begin
                rate_valid <= 1'b0;
                isi_valid  <= 1'b0;

                // An event on the closing cycle belongs to the closing window.
                if (win_end) begin
                    rate       <= spk_next;
                    rate_valid <= 1'b1;
                    spk_cnt    <= '0;
                    win_cnt    <= '0;
                    len_q      <= win_len_eff;
                end else begin
                    spk_cnt    <= spk_next;
                    win_cnt    <= win_cnt + WIN_W'(1);
                end

                if (spike_evt) begin
                    timer     <= ISI_W'(1);
                    have_prev <= 1'b1;
                    if (have_prev) begin
                        isi       <= timer;
                        isi_valid <= 1'b1;
                    end
                end else begin
                    timer <= timer_next;
                end
            end
        end
    end

endmodule
